multicycle_control: RTL and testbench

//  FSM sequencing a multicycle RV32I-subset datapath (lw, sw, R-type add/sub/and/or/slt, beq) over one shared

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I-subset control FSM with memory ready handshake and wait timeout
`timescale 1ns/1ps
module multicycle_control #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic        EQ,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUctrl,
    output logic        illegal,
    output logic        timeout
);
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_ALUWB, S_BEQ, S_TRAP
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [6:0]    op;
    logic [2:0]    funct3;
    logic          funct7b5;
    logic          mem_state;
    logic          expired;
    logic          r_ok;
    logic          instr_unused;

    assign op           = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign funct7b5     = Instr[30];
    assign instr_unused = ^{Instr[31], Instr[29:15], Instr[11:7]};
    assign mem_state    = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign expired      = (wait_cnt == CW'(TIMEOUT)) && !mem_ready;
    assign r_ok         = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                          (funct3 == 3'b110) || (funct3 == 3'b111);

    // Counter stays zero outside wait cycles, so it is already clear on entry to every memory state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= '0;
            if (mem_state && !mem_ready) begin
                if (expired) begin
                    state   <= S_TRAP;
                    timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                case (state)
                    S_FETCH:  state <= S_DECODE;
                    S_DECODE: begin
                        if (op == OP_LW || op == OP_SW) begin
                            state <= S_MEMADR;
                        end else if (op == OP_R && r_ok) begin
                            state <= S_EXECR;
                        end else if (op == OP_BEQ) begin
                            state <= S_BEQ;
                        end else begin
                            state   <= S_TRAP;
                            illegal <= 1'b1;
                        end
                    end
                    S_MEMADR:  state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                    S_MEMREAD: state <= S_MEMWB;
                    S_EXECR:   state <= S_ALUWB;
                    S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state <= S_FETCH;
                    default:   state <= S_TRAP;
                endcase
            end
        end
    end

    always_comb begin
        ImmSrc = 2'b00;
        if (op == OP_SW)       ImmSrc = 2'b01;
        else if (op == OP_BEQ) ImmSrc = 2'b10;
    end

    // Strobes follow the state; only the handshake cycle of a memory state and EQ in BEQ qualify them.
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUctrl   = 3'b000;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    case (funct3)
                        3'b000:  ALUctrl = funct7b5 ? 3'b001 : 3'b000;
                        3'b010:  ALUctrl = 3'b101;
                        3'b110:  ALUctrl = 3'b011;
                        3'b111:  ALUctrl = 3'b010;
                        default: ALUctrl = 3'b000;
                    endcase
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA = 2'b10;
                    ALUctrl = 3'b001;
                    PCWrite = EQ;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed and randomized checks of multicycle_control against a cycle-trace model
`timescale 1ns/1ps
module tb_multicycle_control;
    localparam int TMO = 4;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011, OP_BEQ = 7'b1100011;

    // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, illegal, timeout}
    localparam logic [16:0] F_WAIT  = {6'b100000, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00};
    localparam logic [16:0] F_DONE  = {6'b100110, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00};
    localparam logic [16:0] DEC     = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] MA      = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] MR      = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] MWB     = {6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00};
    localparam logic [16:0] MW      = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] AWB     = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [16:0] TRAP_IL = 17'h00002;
    localparam logic [16:0] TRAP_TO = 17'h00001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Instr = 32'h0;
    logic        EQ = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal, timeout;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUctrl;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [16:0] exp_q[$];
    logic        rdy_q[$];
    logic        eq_q[$];

    multicycle_control #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .EQ(EQ), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    wire [16:0] obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, illegal, timeout};

    function automatic logic [16:0] ex_rec(input logic [2:0] alu);
        return {6'b000000, 2'b10, 2'b00, 2'b00, alu, 2'b00};
    endfunction

    function automatic logic [16:0] beq_rec(input logic e);
        return {4'b0000, e, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00};
    endfunction

    function automatic logic [2:0] alu_of(input logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return ins[30] ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [31:0] ins);
        if (ins[6:0] == OP_SW)  return 2'b01;
        if (ins[6:0] == OP_BEQ) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int pick_wait();
        int r = $urandom_range(0, 9);
        if (r < 5) return 0;
        if (r < 8) return $urandom_range(1, TMO);
        return $urandom_range(TMO, TMO + 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [16:0] r, input logic rdy, input logic e);
        exp_q.push_back(r);
        rdy_q.push_back(rdy);
        eq_q.push_back(e);
    endtask

    // A memory access with w not-ready cycles: completes if w <= TMO, otherwise traps after TMO+1 waits.
    task automatic mem_phase(input logic [16:0] wrec, input logic [16:0] drec, input int w, output bit trapped);
        int n = (w > TMO) ? TMO + 1 : w;
        for (int i = 0; i < n; i++) push(wrec, 1'b0, 1'($urandom_range(0, 1)));
        trapped = (w > TMO);
        if (trapped) begin
            for (int i = 0; i < 3; i++) push(TRAP_TO, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end else begin
            push(drec, 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if (obs !== F_WAIT) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, F_WAIT);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (obs !== F_WAIT) begin
            n_fail++;
            $display("FAIL fetch_hold: got %h expected %h", obs, F_WAIT);
        end
        tick();
    endtask

    task automatic test_lw();
        logic [16:0] exp [6];
        exp[0] = F_DONE; exp[1] = DEC; exp[2] = MA; exp[3] = MR; exp[4] = MWB; exp[5] = F_DONE;
        do_reset();
        Instr = 32'h0081_2283;
        mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp[c]) begin
                n_fail++;
                $display("FAIL lw_cycle%0d: got %h expected %h", c + 1, obs, exp[c]);
            end
            tick();
        end
    endtask

    task automatic test_sw_wait();
        int mw_cnt = 0;
        bit rw_seen = 1'b0;
        do_reset();
        Instr = 32'h0020_A223;
        for (int c = 1; c <= 8; c++) begin
            mem_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (MemWrite === 1'b1) mw_cnt++;
            if (RegWrite !== 1'b0) rw_seen = 1'b1;
            if (c == 2) begin
                n_tests++;
                if (ImmSrc !== 2'b01) begin
                    n_fail++;
                    $display("FAIL sw_immsrc: got %b expected 01", ImmSrc);
                end
            end
            if (c == 8) begin
                n_tests++;
                if (obs !== F_DONE) begin
                    n_fail++;
                    $display("FAIL sw_back_to_fetch: got %h expected %h", obs, F_DONE);
                end
            end
            tick();
        end
        n_tests++;
        if (mw_cnt != 4) begin
            n_fail++;
            $display("FAIL sw_memwrite_cycles: got %0d expected 4", mw_cnt);
        end
        n_tests++;
        if (rw_seen) begin
            n_fail++;
            $display("FAIL sw_regwrite: got 1 expected 0");
        end
    endtask

    task automatic test_rtype();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b000, 3'b111, 3'b010, 3'b110};
        logic        b30s [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0]  alus [5] = '{3'b001, 3'b000, 3'b010, 3'b101, 3'b011};
        logic [16:0] exp;
        do_reset();
        mem_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            Instr = {1'b0, b30s[t], 5'b0, 5'd3, 5'd2, f3s[t], 5'd1, OP_R};
            for (int c = 1; c <= 4; c++) begin
                exp = (c == 1) ? F_DONE : (c == 2) ? DEC : (c == 3) ? ex_rec(alus[t]) : AWB;
                @(negedge clk);
                n_tests++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL rtype%0d_cycle%0d: got %h expected %h", t, c, obs, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_beq();
        logic [16:0] exp;
        do_reset();
        for (int e = 1; e >= 0; e--) begin
            Instr = {7'b0, 5'd2, 5'd1, 3'b000, 5'b0, OP_BEQ};
            EQ = 1'(e);
            for (int c = 1; c <= 4; c++) begin
                mem_ready = (c != 4);
                exp = (c == 1) ? F_DONE : (c == 2) ? DEC : (c == 3) ? beq_rec(1'(e)) : F_WAIT;
                @(negedge clk);
                n_tests++;
                if ({obs, ImmSrc} !== {exp, 2'b10}) begin
                    n_fail++;
                    $display("FAIL beq_eq%0d_cycle%0d: got %h expected %h", e, c, {obs, ImmSrc}, {exp, 2'b10});
                end
                tick();
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2] = '{32'h0010_0093, {7'b0, 5'd2, 5'd1, 3'b001, 5'd3, OP_R}};
        logic [16:0] exp;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            Instr = bad[t];
            for (int c = 1; c <= 7; c++) begin
                mem_ready = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                exp = (c == 1) ? F_DONE : (c == 2) ? DEC : TRAP_IL;
                @(negedge clk);
                n_tests++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL illegal%0d_cycle%0d: got %h expected %h", t, c, obs, exp);
                end
                tick();
            end
            do_reset();
            @(negedge clk);
            n_tests++;
            if (obs !== F_WAIT) begin
                n_fail++;
                $display("FAIL illegal%0d_cleared: got %h expected %h", t, obs, F_WAIT);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [16:0] exp;
        do_reset();
        Instr = 32'h0081_2283;
        for (int c = 1; c <= 6; c++) begin
            mem_ready = (c == 5);
            exp = (c < 5) ? F_WAIT : (c == 5) ? F_DONE : DEC;
            @(negedge clk);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL ready_at_limit_cycle%0d: got %h expected %h", c, obs, exp);
            end
            tick();
        end
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            mem_ready = (c == 7);
            exp = (c <= TMO + 1) ? F_WAIT : TRAP_TO;
            @(negedge clk);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got %h expected %h", c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_random(input int count);
        logic [6:0] bad_ops [4] = '{7'b0010011, 7'b0110111, 7'b1101111, 7'b0000000};
        logic [2:0] bad_f3  [4] = '{3'b001, 3'b011, 3'b100, 3'b101};
        logic [2:0] good_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        do_reset();
        for (int k = 0; k < count; k++) begin
            logic [31:0] ins;
            int          cls;
            bit          trapped;
            logic        e;
            ins = $urandom;
            cls = $urandom_range(0, 5);
            exp_q.delete();
            rdy_q.delete();
            eq_q.delete();
            case (cls)
                0: begin ins[6:0] = OP_LW; ins[14:12] = 3'b010; end
                1: begin ins[6:0] = OP_SW; ins[14:12] = 3'b010; end
                2: begin ins[6:0] = OP_R;  ins[14:12] = good_f3[$urandom_range(0, 3)]; end
                3: begin ins[6:0] = OP_BEQ; ins[14:12] = 3'b000; end
                4: ins[6:0] = bad_ops[$urandom_range(0, 3)];
                default: begin ins[6:0] = OP_R; ins[14:12] = bad_f3[$urandom_range(0, 3)]; end
            endcase
            mem_phase(F_WAIT, F_DONE, pick_wait(), trapped);
            if (!trapped) begin
                push(DEC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                case (cls)
                    0: begin
                        push(MA, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        mem_phase(MR, MR, pick_wait(), trapped);
                        if (!trapped) push(MWB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    end
                    1: begin
                        push(MA, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        mem_phase(MW, MW, pick_wait(), trapped);
                    end
                    2: begin
                        push(ex_rec(alu_of(ins)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        push(AWB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    end
                    3: begin
                        e = 1'($urandom_range(0, 1));
                        push(beq_rec(e), 1'($urandom_range(0, 1)), e);
                    end
                    default: begin
                        for (int i = 0; i < 3; i++) push(TRAP_IL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        trapped = 1'b1;
                    end
                endcase
            end
            Instr = ins;
            for (int i = 0; i < exp_q.size(); i++) begin
                mem_ready = rdy_q[i];
                EQ = eq_q[i];
                @(negedge clk);
                n_tests++;
                if ({obs, ImmSrc} !== {exp_q[i], imm_of(ins)}) begin
                    n_fail++;
                    $display("FAIL rand%0d_cycle%0d ins=%h: got %h expected %h",
                             k, i + 1, ins, {obs, ImmSrc}, {exp_q[i], imm_of(ins)});
                end
                tick();
            end
            if (trapped) do_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_beq();
        test_illegal();
        test_timeout();
        test_random(120);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
